// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK cells shared by two requesters through a round-robin arbiter.
// Optional grant lock is enabled with `define JK_BANK_LOCK_EN.
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_a,
  input  logic [1:0]       req_op_a,
  input  logic [WIDTH-1:0] req_mask_a,
`ifdef JK_BANK_LOCK_EN
  input  logic             req_lock_a,
`endif
  output logic             req_ready_a,
  output logic             done_a,
  input  logic             req_valid_b,
  input  logic [1:0]       req_op_b,
  input  logic [WIDTH-1:0] req_mask_b,
`ifdef JK_BANK_LOCK_EN
  input  logic             req_lock_b,
  output logic             locked,
`endif
  output logic             req_ready_b,
  output logic             done_b,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] mask_reg;
  logic [1:0]       op_reg;
  logic             last_b_reg;  // 1 when B was granted last (also the current owner)
  logic             accept_a, accept_b, accept;
  logic             lock_hold;

`ifdef JK_BANK_LOCK_EN
  logic lock_pend_reg, locked_reg;
  assign lock_hold = locked_reg;
  assign locked    = locked_reg;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    req_ready_a = 1'b0;
    req_ready_b = 1'b0;
    if (state_reg == IDLE) begin
      if (lock_hold) begin
        // Grant stays with the lock owner; the other side waits.
        req_ready_a = req_valid_a & ~last_b_reg;
        req_ready_b = req_valid_b & last_b_reg;
      end else begin
        req_ready_a = req_valid_a & (~req_valid_b | last_b_reg);
        req_ready_b = req_valid_b & (~req_valid_a | ~last_b_reg);
      end
    end
  end

  assign accept_a = req_valid_a & req_ready_a;
  assign accept_b = req_valid_b & req_ready_b;
  assign accept   = accept_a | accept_b;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-cell JK equation: q+ = j&~q | ~k&q, applied only to masked cells.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign q_next[gi] = (state_reg == APPLY && mask_reg[gi])
                        ? ((op_reg[1] & ~q_reg[gi]) | (~op_reg[0] & q_reg[gi]))
                        : q_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      mask_reg   <= '0;
      op_reg     <= 2'b00;
      last_b_reg <= 1'b1;
`ifdef JK_BANK_LOCK_EN
      lock_pend_reg <= 1'b0;
      locked_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      if (accept) begin
        op_reg     <= accept_b ? req_op_b : req_op_a;
        mask_reg   <= accept_b ? req_mask_b : req_mask_a;
        last_b_reg <= accept_b;
`ifdef JK_BANK_LOCK_EN
        lock_pend_reg <= accept_b ? req_lock_b : req_lock_a;
`endif
      end
`ifdef JK_BANK_LOCK_EN
      // Lock changes take effect from the IDLE after the command's DONE.
      if (state_reg == DONE) locked_reg <= lock_pend_reg;
`endif
    end
  end

  assign q      = q_reg;
  assign busy   = (state_reg != IDLE);
  assign done_a = (state_reg == DONE) & ~last_b_reg;
  assign done_b = (state_reg == DONE) & last_b_reg;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (lock checks when JK_BANK_LOCK_EN is defined).
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic [1:0] req_op_a = 2'b00, req_op_b = 2'b00;
  logic [7:0] req_mask_a = 8'h00, req_mask_b = 8'h00;
  logic       req_ready_a, req_ready_b, done_a, done_b, busy;
  logic [7:0] q;
`ifdef JK_BANK_LOCK_EN
  logic       req_lock_a = 1'b0, req_lock_b = 1'b0;
  logic       locked;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_q = 8'h00;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid_a(req_valid_a), .req_op_a(req_op_a), .req_mask_a(req_mask_a),
`ifdef JK_BANK_LOCK_EN
    .req_lock_a(req_lock_a),
`endif
    .req_ready_a(req_ready_a), .done_a(done_a),
    .req_valid_b(req_valid_b), .req_op_b(req_op_b), .req_mask_b(req_mask_b),
`ifdef JK_BANK_LOCK_EN
    .req_lock_b(req_lock_b), .locked(locked),
`endif
    .req_ready_b(req_ready_b), .done_b(done_b),
    .busy(busy), .q(q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full command from A (is_b=0) or B (is_b=1), checked through every phase.
  task automatic send(input logic is_b, input logic [1:0] op, input logic [7:0] mask,
                      input logic [7:0] exp_q);
    @(negedge clk);
    if (is_b) begin req_valid_b = 1'b1; req_op_b = op; req_mask_b = mask; end
    else      begin req_valid_a = 1'b1; req_op_a = op; req_mask_a = mask; end
    #1;
    check("ready_a", req_ready_a, !is_b);
    check("ready_b", req_ready_b, is_b);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    check("apply_busy", busy, 1'b1);
    check("apply_q", q, prev_q);
    check("apply_done", {done_a, done_b}, 2'b00);
    @(posedge clk); #1;
    check("done_q", q, exp_q);
    check("done_pulse", {done_a, done_b}, is_b ? 2'b01 : 2'b10);
    check("done_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);
    check("idle_done", {done_a, done_b}, 2'b00);
    prev_q = exp_q;
    $display("cmd %s op=%b mask=%h q=%h", is_b ? "B" : "A", op, mask, q);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prev_q = 8'h00;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", {done_a, done_b}, 2'b00);
    check("rst_ready", {req_ready_a, req_ready_b}, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    send(1'b0, 2'b10, 8'h0F, 8'h0F);
    send(1'b1, 2'b11, 8'hFF, 8'hF0);
    send(1'b0, 2'b01, 8'h30, 8'hC0);
    send(1'b0, 2'b00, 8'hFF, 8'hC0);
    send(1'b0, 2'b10, 8'h00, 8'hC0);

    // Contention: both valid continuously, grants alternate every 3 cycles
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        req_valid_a = 1'b1; req_op_a = 2'b11; req_mask_a = 8'h03;
        req_valid_b = 1'b1; req_op_b = 2'b11; req_mask_b = 8'h03;
      end
      #1;
      check("rr_ready_a", req_ready_a, (cyc % 3 == 0) && ((cyc / 3) % 2 == 0));
      check("rr_ready_b", req_ready_b, (cyc % 3 == 0) && ((cyc / 3) % 2 == 1));
      if (cyc % 3 == 0)
        $display("rr cycle %0d ready_a=%b ready_b=%b", cyc, req_ready_a, req_ready_b);
    end
    check("rr_q", q, 8'h00);
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    @(posedge clk); #1;
    check("rr_idle", busy, 1'b0);

    // Reset during APPLY drops the command and restores the pointer
    do_reset();
    send(1'b0, 2'b10, 8'h0F, 8'h0F);
    @(negedge clk);
    req_valid_a = 1'b1; req_op_a = 2'b11; req_mask_a = 8'hFF;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check("mid_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_q", q, 8'h00);
    check("mid_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("mid_done", {done_a, done_b}, 2'b00);
    check("mid_q_hold", q, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    req_valid_a = 1'b1; req_valid_b = 1'b1;
    req_op_a = 2'b00; req_op_b = 2'b00;
    #1;
    check("post_rst_ready_a", req_ready_a, 1'b1);
    check("post_rst_ready_b", req_ready_b, 1'b0);
    $display("reset in APPLY: q=%h ready_a=%b ready_b=%b", q, req_ready_a, req_ready_b);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    repeat (3) @(posedge clk);

`ifdef JK_BANK_LOCK_EN
    // A locks for three grants, then releases with its fourth; B follows
    do_reset();
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        req_valid_a = 1'b1; req_op_a = 2'b00; req_mask_a = 8'h00;
        req_valid_b = 1'b1; req_op_b = 2'b00; req_mask_b = 8'h00;
        req_lock_b = 1'b0;
      end
      req_lock_a = (cyc < 9);
      #1;
      check("lk_ready_a", req_ready_a, (cyc % 3 == 0) && (cyc < 12));
      check("lk_ready_b", req_ready_b, cyc == 12);
      check("lk_locked", locked, (cyc >= 3) && (cyc < 12));
      if (cyc % 3 == 0)
        $display("lock cycle %0d ready_a=%b ready_b=%b locked=%b",
                 cyc, req_ready_a, req_ready_b, locked);
    end
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    @(posedge clk); #1;
    check("lk_end_locked", locked, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
